// File: rtl/gtp_pll_init.sv
// GTPE2_COMMON PLL0 power-up sequencer.
// Walks the PLL through power-down, reset and lock acquisition, retries on lock
// timeout, and watches a locked PLL for loss of lock. All outputs are registered.
module gtp_pll_init #(
  parameter int PD_CYCLES    = 64,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int LOCK_STABLE  = 8,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pll_lock,
  output logic       pll_pd,
  output logic       pll_reset,
  output logic       pll_lock_en,
  output logic       done,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retries
);

  // Counter widths: one spare bit over clog2 so the terminal value always fits.
  localparam int PD_W  = $clog2(PD_CYCLES) + 1;
  localparam int RST_W = $clog2(RST_CYCLES) + 1;
  localparam int TO_W  = $clog2(LOCK_TIMEOUT) + 1;
  localparam int STB_W = $clog2(LOCK_STABLE) + 1;

  // Terminal values, pre-sized to the counters they are compared against.
  localparam logic [PD_W-1:0]  PD_LAST  = PD_W'(PD_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
  localparam logic [STB_W-1:0] STB_MAX  = {STB_W{1'b1}};
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POWERDOWN,
    ST_RESET,
    ST_WAIT_LOCK,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  state_t           state_reg;
  logic [PD_W-1:0]  pd_cnt_reg;
  logic [RST_W-1:0] rst_cnt_reg;
  logic [TO_W-1:0]  to_cnt_reg;
  logic [STB_W-1:0] stable_cnt_reg;
  logic [3:0]       retries_reg;
  logic             pll_pd_reg;
  logic             pll_reset_reg;
  logic             pll_lock_en_reg;
  logic             done_reg;
  logic             fail_reg;
  logic             lock_lost_reg;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  logic lock_meta_reg;
  logic lock_s;

  // Bring pll_lock into the clk domain; only lock_s is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta_reg <= 1'b0;
      lock_s        <= 1'b0;
    end else begin
      lock_meta_reg <= pll_lock;
      lock_s        <= lock_meta_reg;
    end
  end

  // Sequencer: state, counters and every output update together so outputs
  // always reflect the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      pd_cnt_reg      <= '0;
      rst_cnt_reg     <= '0;
      to_cnt_reg      <= '0;
      stable_cnt_reg  <= '0;
      retries_reg     <= '0;
      pll_pd_reg      <= 1'b1;
      pll_reset_reg   <= 1'b1;
      pll_lock_en_reg <= 1'b0;
      done_reg        <= 1'b0;
      fail_reg        <= 1'b0;
      lock_lost_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            // Fresh sequence: clear all status from any earlier run.
            state_reg     <= ST_POWERDOWN;
            pd_cnt_reg    <= '0;
            retries_reg   <= '0;
            lock_lost_reg <= 1'b0;
            done_reg      <= 1'b0;
            fail_reg      <= 1'b0;
          end
        end

        ST_POWERDOWN: begin
          if (pd_cnt_reg == PD_LAST) begin
            state_reg       <= ST_RESET;
            rst_cnt_reg     <= '0;
            pll_pd_reg      <= 1'b0;
            pll_reset_reg   <= 1'b1;
            pll_lock_en_reg <= 1'b1;
          end else begin
            pd_cnt_reg <= pd_cnt_reg + PD_W'(1);
          end
        end

        ST_RESET: begin
          if (rst_cnt_reg == RST_LAST) begin
            state_reg      <= ST_WAIT_LOCK;
            to_cnt_reg     <= '0;
            stable_cnt_reg <= '0;
            pll_reset_reg  <= 1'b0;
          end else begin
            rst_cnt_reg <= rst_cnt_reg + RST_W'(1);
          end
        end

        ST_WAIT_LOCK: begin
          if (lock_s && (stable_cnt_reg == STB_LAST)) begin
            // Stable lock is checked first so it wins a tie with the timeout.
            state_reg <= ST_LOCKED;
            done_reg  <= 1'b1;
          end else if (to_cnt_reg == TO_LAST) begin
            if (retries_reg < RETRY_LIMIT) begin
              state_reg     <= ST_RESET;
              rst_cnt_reg   <= '0;
              pll_reset_reg <= 1'b1;
              if (retries_reg != 4'hF) begin
                retries_reg <= retries_reg + 4'd1;
              end
            end else begin
              // Out of attempts: park the PLL powered down and flag failure.
              state_reg       <= ST_FAIL;
              fail_reg        <= 1'b1;
              pll_pd_reg      <= 1'b1;
              pll_reset_reg   <= 1'b1;
              pll_lock_en_reg <= 1'b0;
            end
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
            if (!lock_s) begin
              stable_cnt_reg <= '0;
            end else if (stable_cnt_reg != STB_MAX) begin
              stable_cnt_reg <= stable_cnt_reg + STB_W'(1);
            end
          end
        end

        ST_LOCKED: begin
          if (start) begin
            state_reg       <= ST_POWERDOWN;
            pd_cnt_reg      <= '0;
            retries_reg     <= '0;
            lock_lost_reg   <= 1'b0;
            done_reg        <= 1'b0;
            fail_reg        <= 1'b0;
            pll_pd_reg      <= 1'b1;
            pll_reset_reg   <= 1'b1;
            pll_lock_en_reg <= 1'b0;
          end else if (!lock_s) begin
            // Lock dropped: re-run reset without spending a retry.
            state_reg     <= ST_RESET;
            rst_cnt_reg   <= '0;
            lock_lost_reg <= 1'b1;
            done_reg      <= 1'b0;
            pll_reset_reg <= 1'b1;
          end
        end

        ST_FAIL: begin
          if (start) begin
            state_reg     <= ST_POWERDOWN;
            pd_cnt_reg    <= '0;
            retries_reg   <= '0;
            lock_lost_reg <= 1'b0;
            done_reg      <= 1'b0;
            fail_reg      <= 1'b0;
          end
        end

        default: begin
          state_reg       <= ST_IDLE;
          pll_pd_reg      <= 1'b1;
          pll_reset_reg   <= 1'b1;
          pll_lock_en_reg <= 1'b0;
          done_reg        <= 1'b0;
          fail_reg        <= 1'b0;
        end
      endcase
    end
  end

  assign pll_pd      = pll_pd_reg;
  assign pll_reset   = pll_reset_reg;
  assign pll_lock_en = pll_lock_en_reg;
  assign done        = done_reg;
  assign fail        = fail_reg;
  assign lock_lost   = lock_lost_reg;
  assign retries     = retries_reg;

endmodule

// File: tb/tb_gtp_pll_init.sv
// Directed bench for gtp_pll_init with default parameters.
// Cycle n starts at clock edge n; start presented in cycle 0 is sampled at edge 1.
module tb_gtp_pll_init;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_pd;
  logic       pll_reset;
  logic       pll_lock_en;
  logic       done;
  logic       fail;
  logic       lock_lost;
  logic [3:0] retries;

  int checks = 0;
  int failures = 0;

  gtp_pll_init dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pll_lock    (pll_lock),
    .pll_pd      (pll_pd),
    .pll_reset   (pll_reset),
    .pll_lock_en (pll_lock_en),
    .done        (done),
    .fail        (fail),
    .lock_lost   (lock_lost),
    .retries     (retries)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pd"}, {31'd0, pll_pd}, 32'd1);
    check({tag, "_reset"}, {31'd0, pll_reset}, 32'd1);
    check({tag, "_lock_en"}, {31'd0, pll_lock_en}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_fail"}, {31'd0, fail}, 32'd0);
    check({tag, "_lock_lost"}, {31'd0, lock_lost}, 32'd0);
    check({tag, "_retries"}, {28'd0, retries}, 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    int pulse_len;
    int bad_len;
    logic in_rst_prev;
    logic in_rst_now;

    // Reset state
    #23;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_reset_outputs("idle");

    // Nominal sequence
    start = 1'b1;
    tick();
    start = 1'b0;
    check("nom_pd_c1", {31'd0, pll_pd}, 32'd1);
    repeat (63) tick();
    check("nom_pd_c64", {31'd0, pll_pd}, 32'd1);
    tick();
    check("nom_pd_c65", {31'd0, pll_pd}, 32'd0);
    check("nom_reset_c65", {31'd0, pll_reset}, 32'd1);
    check("nom_lock_en_c65", {31'd0, pll_lock_en}, 32'd1);
    repeat (15) tick();
    check("nom_reset_c80", {31'd0, pll_reset}, 32'd1);
    tick();
    check("nom_reset_c81", {31'd0, pll_reset}, 32'd0);
    repeat (100) tick();
    pll_lock = 1'b1;
    repeat (9) tick();
    check("nom_done_9", {31'd0, done}, 32'd0);
    tick();
    check("nom_done_10", {31'd0, done}, 32'd1);
    check("nom_retries", {28'd0, retries}, 32'd0);
    $display("nominal: done after 10 cycles of lock, retries=%0d", retries);

    // Glitchy lock: restart from LOCKED
    pll_lock = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("glitch_restart_done", {31'd0, done}, 32'd0);
    repeat (80) tick();
    check("glitch_wait_entry", {31'd0, pll_reset}, 32'd0);
    pll_lock = 1'b1;
    repeat (5) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    repeat (9) tick();
    check("glitch_done_9", {31'd0, done}, 32'd0);
    tick();
    check("glitch_done_10", {31'd0, done}, 32'd1);
    check("glitch_lock_lost", {31'd0, lock_lost}, 32'd0);
    $display("glitch: done after 8 stable synchronized cycles");

    // Lock loss while LOCKED
    pll_lock = 1'b0;
    repeat (2) tick();
    check("loss_done_2", {31'd0, done}, 32'd1);
    tick();
    check("loss_done_3", {31'd0, done}, 32'd0);
    check("loss_lost_3", {31'd0, lock_lost}, 32'd1);
    check("loss_pd_3", {31'd0, pll_pd}, 32'd0);
    check("loss_reset_3", {31'd0, pll_reset}, 32'd1);
    pll_lock = 1'b1;
    repeat (23) tick();
    check("relock_done_23", {31'd0, done}, 32'd0);
    tick();
    check("relock_done_24", {31'd0, done}, 32'd1);
    check("relock_lost", {31'd0, lock_lost}, 32'd1);
    check("relock_retries", {28'd0, retries}, 32'd0);
    $display("lock loss: lock_lost=%0d done=%0d after relock", lock_lost, done);

    // Timeout and retry until FAIL
    pll_lock = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    check("to_lost_cleared", {31'd0, lock_lost}, 32'd0);
    pulses = 0;
    pulse_len = 0;
    bad_len = 0;
    in_rst_prev = 1'b0;
    while (!fail && n < 6000) begin
      tick();
      n++;
      in_rst_now = !pll_pd && pll_reset;
      if (in_rst_now) begin
        if (!in_rst_prev) pulses++;
        pulse_len++;
      end else if (in_rst_prev) begin
        if (pulse_len != 16) bad_len++;
        pulse_len = 0;
      end
      in_rst_prev = in_rst_now;
    end
    check("to_fail", {31'd0, fail}, 32'd1);
    check("to_fail_cycle", n, 32'd4225);
    check("to_pulses", pulses, 32'd4);
    check("to_bad_len", bad_len, 32'd0);
    check("to_retries", {28'd0, retries}, 32'd3);
    check("to_pd", {31'd0, pll_pd}, 32'd1);
    check("to_reset", {31'd0, pll_reset}, 32'd1);
    check("to_lock_en", {31'd0, pll_lock_en}, 32'd0);
    $display("timeout: %0d reset pulses, fail at cycle %0d, retries=%0d", pulses, n, retries);

    // Restart from FAIL clears fail and retries
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fail_clr_fail", {31'd0, fail}, 32'd0);
    check("fail_clr_retries", {28'd0, retries}, 32'd0);
    $display("restart from fail: fail=%0d retries=%0d", fail, retries);

    // Boundary: stable lock completes on the timeout cycle -> lock wins
    repeat (1094) tick();
    pll_lock = 1'b1;
    repeat (10) tick();
    check("bnd_done", {31'd0, done}, 32'd1);
    check("bnd_retries", {28'd0, retries}, 32'd0);
    check("bnd_reset", {31'd0, pll_reset}, 32'd0);
    $display("boundary tie: done=%0d retries=%0d", done, retries);

    // One cycle later the timeout fires first -> retry
    pll_lock = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (1095) tick();
    pll_lock = 1'b1;
    repeat (10) tick();
    check("late_done", {31'd0, done}, 32'd0);
    check("late_retries", {28'd0, retries}, 32'd1);
    check("late_in_reset", {30'd0, pll_pd, pll_reset}, 32'd1);
    $display("late lock: retries=%0d", retries);

    // Asynchronous reset mid-WAIT_LOCK, off the clock edge
    pll_lock = 1'b0;
    repeat (20) tick();
    check("ar_in_wait", {31'd0, pll_reset}, 32'd0);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("ar_async");
    start = 1'b1;
    repeat (3) tick();
    check_reset_outputs("ar_held");
    start = 1'b0;
    #2;
    rst = 1'b0;
    repeat (100) tick();
    check("ar_idle_pd", {31'd0, pll_pd}, 32'd1);
    check("ar_idle_lock_en", {31'd0, pll_lock_en}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (63) tick();
    check("ar_pd_c64", {31'd0, pll_pd}, 32'd1);
    tick();
    check("ar_pd_c65", {31'd0, pll_pd}, 32'd0);
    $display("async reset: outputs cleared, clean restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gtp_pll_init.md
GTP_PLL_INIT -- requirements
Module: gtp_pll_init

Interface
REQ-001 SHALL have parameter PD_CYCLES, default 64: cycles pll_pd is held high in POWERDOWN (min 1).
REQ-002 SHALL have parameter RST_CYCLES, default 16: cycles pll_reset is held high in RESET (min 1).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 1024: maximum cycles spent in WAIT_LOCK per attempt.
REQ-004 SHALL have parameter LOCK_STABLE, default 8: consecutive synchronized lock-high cycles required to declare lock.
REQ-005 SHALL have parameter MAX_RETRIES, default 3: reset attempts after the first before FAIL (0..15).
REQ-006 SHALL have one clock and an asynchronous, active-high reset.
REQ-007 clk  input  1  sole clock; all logic on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  level-sampled request to (re)start the power-up sequence.
REQ-010 pll_lock  input  1  PLL0LOCK from GTPE2_COMMON, asynchronous to clk.
REQ-011 pll_pd  output  1  drives PLL0PD.
REQ-012 pll_reset  output  1  drives PLL0RESET.
REQ-013 pll_lock_en  output  1  drives PLL0LOCKEN.
REQ-014 done  output  1  PLL locked and stable.
REQ-015 fail  output  1  retries exhausted.
REQ-016 lock_lost  output  1  sticky flag: lock dropped while in LOCKED.
REQ-017 retries  output  4  attempts made beyond the first in the current sequence.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 pll_lock SHALL pass through a 2-flop synchronizer (lock_s) before use; total lock-to-decision latency is 2 cycles plus LOCK_STABLE.
REQ-020 FSM states: IDLE, POWERDOWN, RESET, WAIT_LOCK, LOCKED, FAIL.
REQ-021 IDLE: pll_pd=1, pll_reset=1, pll_lock_en=0; start=1 -> POWERDOWN next cycle, with retries and lock_lost cleared.
REQ-022 POWERDOWN: pll_pd=1, pll_reset=1 for exactly PD_CYCLES cycles, then -> RESET.
REQ-023 RESET: pll_pd=0, pll_reset=1, pll_lock_en=1 for exactly RST_CYCLES cycles, then -> WAIT_LOCK.
REQ-024 WAIT_LOCK: pll_pd=0, pll_reset=0, pll_lock_en=1.
REQ-025 In WAIT_LOCK, the stable counter SHALL increment on lock_s=1 and clear on lock_s=0.
REQ-026 In WAIT_LOCK, a stable count of LOCK_STABLE SHALL transition to LOCKED.
REQ-027 In WAIT_LOCK, the timeout counter SHALL run from 0 on entry; at LOCK_TIMEOUT cycles without lock: retries<MAX_RETRIES -> retries+1, -> RESET; otherwise -> FAIL.
REQ-028 If stable lock and timeout occur in the same cycle, lock SHALL win.
REQ-029 LOCKED: done=1; lock_s=0 -> lock_lost=1, done=0 next cycle, -> RESET; retries is not incremented, and retries is not cleared.
REQ-030 FAIL: fail=1, pll_pd=1, pll_reset=1, held until start.
REQ-031 start=1 in LOCKED or FAIL SHALL -> POWERDOWN, clearing done, fail, retries and lock_lost.
REQ-032 start SHALL be ignored in POWERDOWN, RESET and WAIT_LOCK.
REQ-033 retries SHALL saturate at 15.
REQ-034 All counters SHALL be sized as clog2 of their parameter plus 1, and SHALL never wrap.

Reset
REQ-035 rst=1 SHALL immediately force IDLE and clear all counters and synchronizer flops.
REQ-036 During and after rst: pll_pd=1, pll_reset=1, pll_lock_en=0, done=0, fail=0, lock_lost=0, retries=0.
REQ-037 rst asserted mid-sequence SHALL abort the sequence; no state is retained.

Verification
REQ-038 Nominal: defaults; start pulse at cycle 0; pll_lock rises 100 cycles after WAIT_LOCK entry -> pll_pd falls at cycle 65, pll_reset falls at cycle 81, done=1 exactly 10 cycles after pll_lock rises, retries=0.
REQ-039 Timeout and retry: pll_lock held low -> 4 RESET pulses of 16 cycles each, retries ends at 3, fail=1; a later start clears fail and retries.
REQ-040 Glitchy lock: pll_lock high 5 cycles, low 1 cycle, then high -> done asserts only after 8 consecutive synchronized high cycles.
REQ-041 Lock loss: in LOCKED, drop pll_lock -> done=0 and lock_lost=1 three cycles later, RESET entered; re-lock -> done=1 with lock_lost still 1.
REQ-042 Async reset: assert rst mid-WAIT_LOCK, off clock edge -> outputs reach reset values before the next edge; start is ignored until rst is released.
REQ-043 Boundary: lock_s stable count reaches 8 on the cycle the timeout counter reaches 1024 -> LOCKED, retries unchanged.
